// File: rtl/axis_header_arbiter_pkg.sv
// Shared state encoding and header-legality helper for the header arbiter.
package axis_header_arbiter_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // A header is usable only if it inserts at least one and at most a full word of bytes.
    function automatic logic hdr_cnt_ok(input int unsigned cnt, input int unsigned max_bytes);
        return (cnt != 0) && (cnt <= max_bytes);
    endfunction

endpackage

// File: rtl/axis_header_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester above ptr (wrapping) wins.
module rr_pick #(
    parameter int NUM_REQ    = 4,
    parameter int REQ_IDX_WD = 2
) (
    input  logic [NUM_REQ-1:0]    req,
    input  logic [REQ_IDX_WD-1:0] ptr,
    output logic [NUM_REQ-1:0]    grant,
    output logic [REQ_IDX_WD-1:0] grant_idx,
    output logic                  any_req
);

    logic [REQ_IDX_WD-1:0] cand;
    logic                  found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = REQ_IDX_WD'((int'(ptr) + off) % NUM_REQ);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign any_req = found;

endmodule

// File: rtl/axis_header_arbiter.sv
// Round-robin header arbiter for a shared header-insert datapath.
// Optional statistics counters are enabled by defining HDR_ARB_STATS_EN.
module axis_header_arbiter
    import axis_header_arbiter_pkg::*;
#(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = 2,
    parameter int NUM_REQ      = 4,
    parameter int REQ_IDX_WD   = 2,
    parameter int CNT_WD       = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ*DATA_WD-1:0]           req_data,
    input  logic [NUM_REQ*DATA_BYTE_WD-1:0]      req_keep,
    input  logic [NUM_REQ*(BYTE_CNT_WD+1)-1:0]   req_byte_cnt,
    output logic [NUM_REQ-1:0]                   req_ready,
    output logic                                 valid_insert,
    output logic [DATA_WD-1:0]                   data_insert,
    output logic [DATA_BYTE_WD-1:0]              keep_insert,
    output logic [BYTE_CNT_WD:0]                 byte_insert_cnt,
    input  logic                                 ready_insert,
    input  logic                                 mon_valid,
    input  logic                                 mon_ready,
    input  logic                                 mon_last,
    output logic [REQ_IDX_WD-1:0]                grant_idx,
    output logic                                 busy,
    output logic                                 err_drop
`ifdef HDR_ARB_STATS_EN
    ,
    output logic [NUM_REQ*CNT_WD-1:0]            stat_pkt_cnt,
    output logic [CNT_WD-1:0]                    stat_drop_cnt
`endif
);

    state_t                  state_q, state_d;
    logic [REQ_IDX_WD-1:0]   ptr_q, ptr_d;
    logic [REQ_IDX_WD-1:0]   grant_idx_q, grant_idx_d;
    logic                    valid_insert_q, valid_insert_d;
    logic                    busy_q, busy_d;
    logic                    err_drop_q, err_drop_d;
    logic [DATA_WD-1:0]      data_q, data_d;
    logic [DATA_BYTE_WD-1:0] keep_q, keep_d;
    logic [BYTE_CNT_WD:0]    cnt_q, cnt_d;

    logic [NUM_REQ-1:0]      pick_grant;
    logic [REQ_IDX_WD-1:0]   pick_idx;
    logic                    pick_any;
    logic [DATA_WD-1:0]      sel_data;
    logic [DATA_BYTE_WD-1:0] sel_keep;
    logic [BYTE_CNT_WD:0]    sel_cnt;
    logic                    hdr_ok;
    logic                    pkt_done;
    logic                    unused_ready;

    // ready_insert only qualifies datapath beats, which arrive here through the mon_* ports.
    assign unused_ready = ready_insert;

    rr_pick #(
        .NUM_REQ    (NUM_REQ),
        .REQ_IDX_WD (REQ_IDX_WD)
    ) u_rr_pick (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .any_req   (pick_any)
    );

    always_comb begin
        sel_data = '0;
        sel_keep = '0;
        sel_cnt  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i]) begin
                sel_data = req_data[i*DATA_WD +: DATA_WD];
                sel_keep = req_keep[i*DATA_BYTE_WD +: DATA_BYTE_WD];
                sel_cnt  = req_byte_cnt[i*(BYTE_CNT_WD+1) +: (BYTE_CNT_WD+1)];
            end
        end
    end

    assign hdr_ok   = hdr_cnt_ok(32'(sel_cnt), 32'(DATA_BYTE_WD));
    assign pkt_done = mon_valid & mon_ready & mon_last;

    // Gated by rst so every output reads zero while reset is held, even with requests pending.
    assign req_ready = (state_q == ST_IDLE && !rst) ? pick_grant : '0;

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        grant_idx_d    = grant_idx_q;
        valid_insert_d = valid_insert_q;
        busy_d         = busy_q;
        err_drop_d     = 1'b0;
        data_d         = data_q;
        keep_d         = keep_q;
        cnt_d          = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    ptr_d       = pick_idx;
                    grant_idx_d = pick_idx;
                    if (hdr_ok) begin
                        state_d        = ST_ACTIVE;
                        valid_insert_d = 1'b1;
                        busy_d         = 1'b1;
                        data_d         = sel_data;
                        keep_d         = sel_keep;
                        cnt_d          = sel_cnt;
                    end else begin
                        err_drop_d = 1'b1;
                    end
                end
            end
            ST_ACTIVE: begin
                if (pkt_done) begin
                    state_d        = ST_IDLE;
                    valid_insert_d = 1'b0;
                    busy_d         = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            ptr_q          <= REQ_IDX_WD'(NUM_REQ - 1);
            grant_idx_q    <= '0;
            valid_insert_q <= 1'b0;
            busy_q         <= 1'b0;
            err_drop_q     <= 1'b0;
            data_q         <= '0;
            keep_q         <= '0;
            cnt_q          <= '0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            grant_idx_q    <= grant_idx_d;
            valid_insert_q <= valid_insert_d;
            busy_q         <= busy_d;
            err_drop_q     <= err_drop_d;
            data_q         <= data_d;
            keep_q         <= keep_d;
            cnt_q          <= cnt_d;
        end
    end

    assign valid_insert    = valid_insert_q;
    assign data_insert     = data_q;
    assign keep_insert     = keep_q;
    assign byte_insert_cnt = cnt_q;
    assign grant_idx       = grant_idx_q;
    assign busy            = busy_q;
    assign err_drop        = err_drop_q;

`ifdef HDR_ARB_STATS_EN
    logic [CNT_WD-1:0] pkt_cnt_q [NUM_REQ];
    logic [CNT_WD-1:0] pkt_cnt_d [NUM_REQ];
    logic [CNT_WD-1:0] drop_cnt_q, drop_cnt_d;

    // Packet counters wrap; the drop counter saturates so a flood of bad headers stays visible.
    always_comb begin
        pkt_cnt_d  = pkt_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (state_q == ST_ACTIVE && pkt_done) begin
            pkt_cnt_d[grant_idx_q] = pkt_cnt_q[grant_idx_q] + CNT_WD'(1);
        end
        if (err_drop_q && drop_cnt_q != '1) begin
            drop_cnt_d = drop_cnt_q + CNT_WD'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                pkt_cnt_q[i] <= '0;
            end
            drop_cnt_q <= '0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_comb begin
        stat_pkt_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            stat_pkt_cnt[i*CNT_WD +: CNT_WD] = pkt_cnt_q[i];
        end
    end

    assign stat_drop_cnt = drop_cnt_q;
`endif

endmodule
